uart_tx_frame_mux: RTL and testbench
====================================

Name: uart_tx_frame_mux

Overview:
- Parametrised successor of the UART TX registered output mux.
- Combines frame sequencing and bit selection in one block:
  - a small FSM and bit counter walk through start, data, parity and stop slots;
  - a registered output stage drives the serial line.
- Sits at the UART TX boundary and drives the TX pin directly.
- One serial bit per CLK cycle; CLK is the TX baud clock.

Parameters:
- DATA_WIDTH, 8, payload bits per frame; legal range 5..9.
- STOP_BITS, 1, stop bits per frame; legal values 1 or 2.
- PAR_DEFAULT_EN, 1, parity-enable value loaded at reset into the internal latched-config register.

Ports:
- CLK  input  1  TX baud clock; all state changes on rising edge.
- RST  input  1  asynchronous active-low reset.
- P_DATA  input  DATA_WIDTH  parallel payload; sampled only at the accept edge.
- DATA_VALID  input  1  request to send P_DATA.
- PAR_EN  input  1  1 = append a parity bit; sampled at the accept edge.
- PAR_TYP  input  1  0 = even, 1 = odd; sampled at the accept edge.
- TX_OUT  output  1  registered serial line; idle level 1.
- Busy  output  1  registered; 1 while a frame occupies the line.

Behaviour:
- Reset (RST low, asynchronous, any time including mid-frame):
  - TX_OUT=1, Busy=0.
  - FSM to IDLE; bit counter=0.
  - Latched data=0, latched parity config = PAR_DEFAULT_EN / even.
  - Frame in progress is abandoned, never resumed.
- FSM states and transitions:
  - IDLE -> START -> DATA -> PARITY (only when latched PAR_EN=1) -> STOP -> IDLE.
- Accept rule:
  - A frame is accepted at rising edge k iff Busy==0 and DATA_VALID==1 in the cycle before edge k.
  - At edge k: P_DATA, PAR_EN, PAR_TYP latched; FSM to START; TX_OUT<=0; Busy<=1.
- Frame timing (TX_OUT values, each held exactly one cycle):
  - Data bit i (LSB first) follows edge k+1+i, for i=0..DATA_WIDTH-1.
  - Parity bit, if enabled, follows edge k+1+DATA_WIDTH.
  - Then STOP_BITS cycles of 1.
- Frame length F = 1 + DATA_WIDTH + PAR + STOP_BITS, where PAR = latched PAR_EN.
  - At edge k+F: FSM to IDLE, Busy<=0, TX_OUT stays 1.
- Busy and TX_OUT come from the same register stage, so they change on the same edge. There is no combinational path from any input to either output.
- Parity:
  - Computed from the latched data at accept: even = XOR of all data bits; odd = inverted XOR.
  - Later changes on P_DATA, PAR_EN or PAR_TYP do not affect the frame in flight.
- DATA_VALID while Busy==1 is ignored; it is not queued.
- Back-to-back frames:
  - Earliest next accept is edge k+F+1.
  - Therefore at least one idle 1-cycle follows the final stop bit.
- DATA_VALID held high continuously: frames repeat with period F+1.
- Bit counter:
  - Width clog2(DATA_WIDTH), counts 0..DATA_WIDTH-1 in DATA.
  - Cleared on leaving DATA; it never wraps beyond DATA_WIDTH-1.
- Illegal parameter values are rejected at elaboration; simulation fatal in the bench.

Test Plan:
- Reset, then idle:
  - RST low with random inputs -> TX_OUT=1, Busy=0.
  - After release with DATA_VALID=0 for 20 cycles -> outputs unchanged.
- Even parity (DATA_WIDTH=8, STOP_BITS=1):
  - P_DATA=0xA5, PAR_EN=1, PAR_TYP=0, one-cycle DATA_VALID.
  - TX_OUT sequence 0,1,0,1,0,0,1,0,1,0,1 over 11 cycles; Busy high exactly 11 cycles.
- Odd parity, same data:
  - PAR_TYP=1 -> parity slot=1; full sequence 0,1,0,1,0,0,1,0,1,1,1.
  - PAR_EN=0 -> 10-cycle frame with no parity slot.
- STOP_BITS=2, DATA_WIDTH=5:
  - P_DATA=0x1F, odd parity -> sequence 0,1,1,1,1,1,0,1,1; Busy high 9 cycles.
- Busy handling and back-to-back:
  - DATA_VALID pulsed mid-frame with P_DATA=0x00 -> ignored; in-flight 0xA5 frame unchanged.
  - DATA_VALID held high -> second start bit appears exactly F+1 cycles after the first.
- Mid-frame reset:
  - RST asserted during data bit 3 -> TX_OUT=1 and Busy=0 immediately, without waiting for a clock edge.
  - After release -> no residual bits until a new accept.

Source files
------------

// File: rtl/uart_tx_frame_mux.sv
// UART transmit framer with a registered serial output.
// A two-process FSM walks through the start, data, parity and stop slots.
// The line bit and the busy flag are both computed one slot ahead and then
// registered together, so they always change on the same clock edge.
module uart_tx_frame_mux #(
  parameter int DATA_WIDTH     = 8,
  parameter int STOP_BITS      = 1,
  parameter bit PAR_DEFAULT_EN = 1'b1
) (
  input  logic                  CLK,
  input  logic                  RST,
  input  logic [DATA_WIDTH-1:0] P_DATA,
  input  logic                  DATA_VALID,
  input  logic                  PAR_EN,
  input  logic                  PAR_TYP,
  output logic                  TX_OUT,
  output logic                  Busy
);

  // Reject configurations that the frame format cannot represent.
  generate
    if (DATA_WIDTH < 5 || DATA_WIDTH > 9) begin : g_bad_data_width
      $error("uart_tx_frame_mux: DATA_WIDTH must be in 5..9");
    end
    if (STOP_BITS != 1 && STOP_BITS != 2) begin : g_bad_stop_bits
      $error("uart_tx_frame_mux: STOP_BITS must be 1 or 2");
    end
  endgenerate

  localparam int                 CNT_W     = $clog2(DATA_WIDTH);
  localparam logic [CNT_W-1:0]   CNT_LAST  = CNT_W'(DATA_WIDTH - 1);
  localparam logic               STOP_LAST = 1'(STOP_BITS - 1);

  // Each state names the slot currently being driven onto the line.
  typedef enum logic [2:0] {
    S_IDLE,
    S_START,
    S_DATA,
    S_PARITY,
    S_STOP
  } state_t;

  state_t                  state;
  state_t                  state_next;
  logic [CNT_W-1:0]        bit_cnt;
  logic [CNT_W-1:0]        bit_cnt_next;
  logic                    stop_cnt;
  logic                    stop_cnt_next;
  logic [DATA_WIDTH-1:0]   data_q;
  logic                    par_en_q;
  logic                    par_typ_q;
  logic                    tx_q;
  logic                    tx_next;
  logic                    busy_q;
  logic                    busy_next;
  logic                    accept;
  logic                    parity_bit;

  // A new frame is taken only while the line is idle; requests while busy
  // are dropped, not queued.
  assign accept     = (state == S_IDLE) && DATA_VALID;
  // Odd parity is even parity inverted; both use the payload latched at accept.
  assign parity_bit = (^data_q) ^ par_typ_q;

  // Next-state and next-line-value logic, one slot ahead of the outputs.
  always_comb begin
    // NOTE: every signal gets a default first so no path leaves it unassigned,
    // which would otherwise infer a latch.
    state_next    = state;
    bit_cnt_next  = bit_cnt;
    stop_cnt_next = stop_cnt;
    tx_next       = 1'b1;
    case (state)
      S_IDLE: begin
        if (DATA_VALID) begin
          state_next = S_START;
          tx_next    = 1'b0;
        end
      end
      S_START: begin
        state_next   = S_DATA;
        bit_cnt_next = '0;
        tx_next      = data_q[0];
      end
      S_DATA: begin
        if (bit_cnt == CNT_LAST) begin
          bit_cnt_next = '0;
          if (par_en_q) begin
            state_next = S_PARITY;
            tx_next    = parity_bit;
          end else begin
            state_next    = S_STOP;
            stop_cnt_next = 1'b0;
          end
        end else begin
          bit_cnt_next = bit_cnt + 1'b1;
          tx_next      = data_q[bit_cnt_next];
        end
      end
      S_PARITY: begin
        state_next    = S_STOP;
        stop_cnt_next = 1'b0;
      end
      S_STOP: begin
        if (stop_cnt == STOP_LAST) begin
          state_next = S_IDLE;
        end else begin
          stop_cnt_next = stop_cnt + 1'b1;
        end
      end
      default: begin
        state_next = S_IDLE;
      end
    endcase
    busy_next = (state_next != S_IDLE);
  end

  // State, counters and the shared output register stage.
  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      state    <= S_IDLE;
      bit_cnt  <= '0;
      stop_cnt <= 1'b0;
      tx_q     <= 1'b1;
      busy_q   <= 1'b0;
    end else begin
      // NOTE: sequential state uses non-blocking assignments so every
      // register samples pre-edge values regardless of statement order.
      state    <= state_next;
      bit_cnt  <= bit_cnt_next;
      stop_cnt <= stop_cnt_next;
      tx_q     <= tx_next;
      busy_q   <= busy_next;
    end
  end

  // Frame configuration captured at the accept edge and held for the frame.
  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      // NOTE: these are plain registers, not a memory, so resetting them is
      // cheap and gives a defined payload and parity mode out of reset.
      data_q    <= '0;
      par_en_q  <= PAR_DEFAULT_EN;
      par_typ_q <= 1'b0;
    end else if (accept) begin
      data_q    <= P_DATA;
      par_en_q  <= PAR_EN;
      par_typ_q <= PAR_TYP;
    end
  end

  assign TX_OUT = tx_q;
  assign Busy   = busy_q;

endmodule

// File: tb/tb_uart_tx_frame_mux.sv
// Scoreboard bench for uart_tx_frame_mux: two instances (8 data bits with
// 1 stop bit, and 5 data bits with 2 stop bits). Stimulus pushes the expected
// per-cycle line values of each frame; a negedge monitor pops and compares.
module tb_uart_tx_frame_mux;

  typedef struct {
    logic tx;
    bit   first;
    bit   last;
    int   start;
  } exp_t;

  logic       clk = 1'b0;
  logic       rst;
  logic [7:0] pd0;
  logic [4:0] pd1;
  logic       dv   [2];
  logic       pen  [2];
  logic       ptyp [2];
  logic       tx   [2];
  logic       busy [2];

  int   cyc    = 0;
  int   checks = 0;
  int   errors = 0;
  exp_t exp_q [2][$];
  bit   in_frame [2];

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  uart_tx_frame_mux #(.DATA_WIDTH(8), .STOP_BITS(1), .PAR_DEFAULT_EN(1'b1)) dut8 (
    .CLK(clk), .RST(rst), .P_DATA(pd0), .DATA_VALID(dv[0]), .PAR_EN(pen[0]),
    .PAR_TYP(ptyp[0]), .TX_OUT(tx[0]), .Busy(busy[0])
  );

  uart_tx_frame_mux #(.DATA_WIDTH(5), .STOP_BITS(2), .PAR_DEFAULT_EN(1'b0)) dut5 (
    .CLK(clk), .RST(rst), .P_DATA(pd1), .DATA_VALID(dv[1]), .PAR_EN(pen[1]),
    .PAR_TYP(ptyp[1]), .TX_OUT(tx[1]), .Busy(busy[1])
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at t=%0t", name, act, exp, $time);
    end
  endtask

  task automatic fail(input string name);
    checks++;
    errors++;
    $display("FAIL %s at t=%0t", name, $time);
  endtask

  task automatic drop_frame(input int d);
    exp_t e;
    while (exp_q[d].size() > 0) begin
      e = exp_q[d].pop_front();
      if (e.last) break;
    end
  endtask

  // Compare one DUT's line against the scoreboard for the current cycle.
  task automatic monitor_dut(input int d);
    exp_t e;
    if (busy[d] === 1'b1) begin
      if (exp_q[d].size() == 0) begin
        fail($sformatf("dut%0d_unexpected_busy", d));
      end else begin
        e = exp_q[d].pop_front();
        if (e.first) check($sformatf("dut%0d_start_cycle", d), cyc, e.start);
        in_frame[d] = !e.last;
        check($sformatf("dut%0d_tx_bit", d), {31'd0, tx[d]}, {31'd0, e.tx});
      end
    end else begin
      check($sformatf("dut%0d_busy_known", d), {31'd0, busy[d]}, 32'd0);
      check($sformatf("dut%0d_idle_tx", d), {31'd0, tx[d]}, 32'd1);
      if (in_frame[d]) begin
        fail($sformatf("dut%0d_busy_dropped_early", d));
        drop_frame(d);
        in_frame[d] = 1'b0;
      end else if (exp_q[d].size() > 0 && exp_q[d][0].first && cyc > exp_q[d][0].start) begin
        fail($sformatf("dut%0d_missed_start", d));
        drop_frame(d);
      end
    end
  endtask

  always @(negedge clk) begin
    for (int d = 0; d < 2; d++) monitor_dut(d);
  end

  // Expected line values written as a string, first character on the wire first.
  task automatic push_frame(input int d, input string seq, input int start);
    exp_t e;
    for (int i = 0; i < seq.len(); i++) begin
      e.tx    = (seq[i] == "1");
      e.first = (i == 0);
      e.last  = (i == seq.len() - 1);
      e.start = start;
      exp_q[d].push_back(e);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic set_data(input int d, input logic [8:0] data);
    if (d == 0) pd0 = data[7:0];
    else        pd1 = data[4:0];
  endtask

  task automatic send(input int d, input logic [8:0] data, input logic pe, input logic pt,
                      input string seq);
    set_data(d, data);
    pen[d]  = pe;
    ptyp[d] = pt;
    dv[d]   = 1'b1;
    push_frame(d, seq, cyc + 1);
    tick(1);
    dv[d] = 1'b0;
    // Disturb the inputs; the frame in flight must not notice.
    set_data(d, ~data);
    pen[d]  = ~pe;
    ptyp[d] = ~pt;
  endtask

  task automatic wait_idle(input int d, input int budget);
    int n = 0;
    while ((exp_q[d].size() != 0 || busy[d] !== 1'b0) && n < budget) begin
      tick(1);
      n++;
    end
    if (n >= budget) begin
      fail($sformatf("dut%0d_wait_idle_timeout", d));
      exp_q[d].delete();
      in_frame[d] = 1'b0;
    end
  endtask

  initial begin
    #200000;
    $display("FAIL global_timeout at t=%0t", $time);
    $fatal(1, "simulation did not terminate");
  end

  initial begin
    // Reset with random inputs and requests asserted.
    rst = 1'b0;
    pd0 = 8'($urandom);
    pd1 = 5'($urandom);
    for (int d = 0; d < 2; d++) begin
      dv[d]   = 1'b1;
      pen[d]  = 1'($urandom);
      ptyp[d] = 1'($urandom);
    end
    tick(3);
    for (int d = 0; d < 2; d++) begin
      check($sformatf("dut%0d_reset_tx", d), {31'd0, tx[d]}, 32'd1);
      check($sformatf("dut%0d_reset_busy", d), {31'd0, busy[d]}, 32'd0);
    end
    dv[0] = 1'b0;
    dv[1] = 1'b0;
    @(negedge clk);
    rst = 1'b1;
    tick(20);
    for (int d = 0; d < 2; d++) begin
      check($sformatf("dut%0d_idle_after_reset_tx", d), {31'd0, tx[d]}, 32'd1);
      check($sformatf("dut%0d_idle_after_reset_busy", d), {31'd0, busy[d]}, 32'd0);
    end

    // 8-bit instance: even, odd, no parity, plus two more patterns.
    send(0, 9'h0A5, 1'b1, 1'b0, "01010010101");  wait_idle(0, 40);
    send(0, 9'h0A5, 1'b1, 1'b1, "01010010111");  wait_idle(0, 40);
    send(0, 9'h0A5, 1'b0, 1'b0, "0101001011");   wait_idle(0, 40);
    send(0, 9'h03C, 1'b1, 1'b0, "00011110001");  wait_idle(0, 40);
    send(0, 9'h001, 1'b1, 1'b1, "01000000001");  wait_idle(0, 40);

    // 5-bit, 2-stop instance.
    send(1, 9'h01F, 1'b1, 1'b1, "011111011");    wait_idle(1, 40);
    send(1, 9'h013, 1'b1, 1'b0, "011001111");    wait_idle(1, 40);
    send(1, 9'h00A, 1'b0, 1'b1, "00101011");     wait_idle(1, 40);

    // Request while busy is ignored and not queued.
    send(0, 9'h0A5, 1'b1, 1'b0, "01010010101");
    tick(3);
    pd0   = 8'h00;
    dv[0] = 1'b1;
    tick(1);
    dv[0] = 1'b0;
    wait_idle(0, 40);

    // Request held high: frames repeat every F+1 = 12 cycles.
    pd0     = 8'hA5;
    pen[0]  = 1'b1;
    ptyp[0] = 1'b0;
    dv[0]   = 1'b1;
    push_frame(0, "01010010101", cyc + 1);
    push_frame(0, "01010010101", cyc + 1 + 12);
    tick(13);
    dv[0] = 1'b0;
    wait_idle(0, 60);

    // Same on the 5-bit instance: F = 9, period 10.
    pd1     = 5'h1F;
    pen[1]  = 1'b1;
    ptyp[1] = 1'b1;
    dv[1]   = 1'b1;
    push_frame(1, "011111011", cyc + 1);
    push_frame(1, "011111011", cyc + 1 + 10);
    tick(11);
    dv[1] = 1'b0;
    wait_idle(1, 60);

    // Asynchronous reset during data bit 3.
    send(0, 9'h0A5, 1'b1, 1'b0, "01010010101");
    tick(4);
    #2;
    rst = 1'b0;
    #1;
    check("midframe_reset_tx", {31'd0, tx[0]}, 32'd1);
    check("midframe_reset_busy", {31'd0, busy[0]}, 32'd0);
    exp_q[0].delete();
    in_frame[0] = 1'b0;
    tick(2);
    rst = 1'b1;
    tick(10);
    check("post_reset_tx", {31'd0, tx[0]}, 32'd1);
    check("post_reset_busy", {31'd0, busy[0]}, 32'd0);
    send(0, 9'h03C, 1'b1, 1'b0, "00011110001");
    wait_idle(0, 40);

    tick(2);
    check("dut0_scoreboard_empty", exp_q[0].size(), 32'd0);
    check("dut1_scoreboard_empty", exp_q[1].size(), 32'd0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
